result_readback_fsm: RTL and testbench
======================================

# result_readback_fsm

Read-side companion to the result address FSM. It tracks how many result records the writer has committed, walking the same slot address sequence (base `STRIDE`, then `2*STRIDE`, …). On host request it fetches each record word-by-word from result memory through a valid handshake and presents the words on a registered output port. It sits between the result memory and the host/export logic.

## Interface
Parameters:
- `STRIDE`, `32'h060E`: byte distance between consecutive result slots. Slot k base is `k*STRIDE`, with k starting at 1.
- `WORDS_PER_RECORD`, `4`: 32-bit words read per record, at byte offsets 0, 4, 8, …
- `NUM_SLOTS`, `8`: number of slots before the read pointer wraps back to slot 1. This is also the maximum pending count.

Ports:
- `clk` in 1: single clock; all logic on posedge.
- `n_rst` in 1: reset, synchronous, active-low.
- `inc_addr` in 1: the same one-cycle pulse the writer receives; each pulse means one record has been committed.
- `rd_req` in 1: host request to read the next pending record; level, sampled in IDLE.
- `mem_rdata` in 32: read data from result memory.
- `mem_rvalid` in 1: `mem_rdata` is valid; honoured only in WAIT.
- `rd_addr` out 32: current memory read byte address.
- `read_enable` out 1: one-cycle memory read strobe.
- `data_out` out 32: last word returned.
- `data_valid` out 1: one-cycle pulse when `data_out` updates.
- `record_done` out 1: one-cycle pulse after the last word of a record.
- `empty` out 1: high when the pending count is 0.
- `overflow` out 1: sticky; the writer got more than `NUM_SLOTS` records ahead.

## Operation
- Registered state:
  - `pending`: 0..`NUM_SLOTS`; width is `$clog2(NUM_SLOTS+1)`.
  - `slot`: 1..`NUM_SLOTS`.
  - `word`: 0..`WORDS_PER_RECORD-1`.
- Address rule: `rd_addr = slot*STRIDE + 4*word`, 32-bit unsigned, truncated. Driven from registers (no combinational path from inputs).
- State machine: IDLE, ISSUE, WAIT.
  - IDLE: if `rd_req && pending!=0`, go to ISSUE. Otherwise stay; `rd_req` while empty is ignored with no memory access.
  - ISSUE: `read_enable=1` for exactly this cycle, then go to WAIT.
  - WAIT: hold until `mem_rvalid`.
    - On `mem_rvalid`, capture `data_out<=mem_rdata` and pulse `data_valid` the next cycle.
    - If `word<WORDS_PER_RECORD-1`: increment `word` and go to ISSUE.
    - Otherwise: clear `word` to 0, pulse `record_done`, decrement `pending`, advance `slot` (`NUM_SLOTS` wraps to 1), and go to IDLE.
- Pending update: +1 on `inc_addr`, −1 on record completion.
  - Both in the same cycle: `pending` is unchanged.
  - `inc_addr` while `pending==NUM_SLOTS` with no same-cycle completion: `pending` saturates and `overflow` is set, held until reset.
- `inc_addr` is counted in every state, including mid-record.
- `empty` is registered and equals `(pending==0)` after each update.

## Timing
- Reset values (cycle after `n_rst` sampled low):
  - state = IDLE, `pending=0`, `slot=1`, `word=0`.
  - `rd_addr=32'h0000060E`, `read_enable=0`, `data_out=0`, `data_valid=0`, `record_done=0`, `empty=1`, `overflow=0`.
- Reset overrides everything, including mid-WAIT. A `mem_rvalid` in the same cycle as reset is dropped.
- `rd_req` at edge t (IDLE, pending>0): ISSUE during cycle t+1, so `read_enable` is high in t+1. WAIT begins t+2.
- `mem_rvalid` sampled at edge u in WAIT:
  - `data_out`/`data_valid` are valid in cycle u+1.
  - The next word's `read_enable` is also in u+1.
  - For the last word, `record_done` is in u+1 and `empty` updates in u+1.
- Minimum 2 cycles per word (ISSUE plus a 1-cycle WAIT). A 4-word record therefore takes at least 8 cycles from ISSUE to `record_done`.
- `mem_rvalid` outside WAIT has no effect.
- `inc_addr` at edge t is reflected in `pending`/`empty` at t+1. A `rd_req` at t+1 can then start a read.

## Test plan
- Reset: hold `n_rst=0` for 2 cycles. Expect `rd_addr=0x060E`, `empty=1`, and all other outputs 0. Then `rd_req=1` with nothing pending: `read_enable` never asserts.
- Single record: pulse `inc_addr` once, then `rd_req`; memory returns 1-cycle-late data AA0, AA1, AA2, AA3.
  - Reads at 0x060E, 0x0612, 0x0616, 0x061A.
  - `data_valid` pulses ×4 with matching data.
  - `record_done` once, then `empty=1` and `rd_addr=0x0C1C`.
- Variable latency: `mem_rvalid` delayed 5 cycles. The FSM holds WAIT, `read_enable` stays low, and `rd_addr` is stable.
- Simultaneous: with `pending=1`, `inc_addr` lands in the same cycle as the final-word `mem_rvalid`. Expect `pending` to stay 1 and `empty` to stay 0.
- Overflow and wrap: 9 `inc_addr` pulses with `NUM_SLOTS=8`. Expect `pending=8` and `overflow=1`. Reading 8 records returns to `rd_addr=0x060E` and `empty=1`; `overflow` stays 1.
- Reset mid-record: assert `n_rst=0` during WAIT of word 2. All outputs return to reset values and a fresh record read restarts at 0x060E.

Source files
------------

// File: rtl/result_readback_fsm.sv
// result_readback_fsm: counts committed result records and reads them back word-by-word on host request.
module result_readback_fsm #(
  parameter logic [31:0] STRIDE           = 32'h060E,
  parameter int          WORDS_PER_RECORD = 4,
  parameter int          NUM_SLOTS        = 8
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        inc_addr,
  input  logic        rd_req,
  input  logic [31:0] mem_rdata,
  input  logic        mem_rvalid,
  output logic [31:0] rd_addr,
  output logic        read_enable,
  output logic [31:0] data_out,
  output logic        data_valid,
  output logic        record_done,
  output logic        empty,
  output logic        overflow
);
  localparam int PW = $clog2(NUM_SLOTS + 1);
  localparam int WW = WORDS_PER_RECORD > 1 ? $clog2(WORDS_PER_RECORD) : 1;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
  state_t        r_state, w_state_nxt;
  logic [PW-1:0] r_pending, r_slot, w_pending_nxt, w_slot_nxt;
  logic [WW-1:0] r_word, w_word_nxt;
  logic [31:0]   w_addr_nxt;
  logic          w_beat, w_done, w_full_inc;
  always_comb begin
    w_beat        = r_state == WAIT && mem_rvalid;
    w_done        = w_beat && r_word == WW'(WORDS_PER_RECORD - 1);
    w_full_inc    = inc_addr && !w_done && r_pending == PW'(NUM_SLOTS);
    w_word_nxt    = w_done ? '0 : w_beat ? r_word + 1'b1 : r_word;
    w_slot_nxt    = !w_done ? r_slot : r_slot == PW'(NUM_SLOTS) ? PW'(1) : r_slot + 1'b1;
    // a completion and a commit in the same cycle cancel; a commit when full saturates
    w_pending_nxt = (inc_addr == w_done || w_full_inc) ? r_pending :
                    inc_addr ? r_pending + 1'b1 : r_pending - 1'b1;
    w_state_nxt   = r_state == IDLE  ? ((rd_req && r_pending != '0) ? ISSUE : IDLE) :
                    r_state == ISSUE ? WAIT :
                    w_done ? IDLE : w_beat ? ISSUE : WAIT;
    w_addr_nxt    = 32'(w_slot_nxt) * STRIDE + 32'({w_word_nxt, 2'b00});
  end
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      r_state     <= IDLE;
      r_pending   <= '0;
      r_slot      <= PW'(1);
      r_word      <= '0;
      rd_addr     <= STRIDE;
      read_enable <= 1'b0;
      data_out    <= '0;
      data_valid  <= 1'b0;
      record_done <= 1'b0;
      empty       <= 1'b1;
      overflow    <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_pending   <= w_pending_nxt;
      r_slot      <= w_slot_nxt;
      r_word      <= w_word_nxt;
      rd_addr     <= w_addr_nxt;
      read_enable <= w_state_nxt == ISSUE;
      data_out    <= w_beat ? mem_rdata : data_out;
      data_valid  <= w_beat;
      record_done <= w_done;
      empty       <= w_pending_nxt == '0;
      overflow    <= overflow | w_full_inc;
    end
  end
endmodule

// File: tb/tb_result_readback_fsm.sv
// tb_result_readback_fsm: cycle-accurate vector table plus directed latency, reset and overflow/wrap sequences.
module tb_result_readback_fsm;
  logic        clk, n_rst, inc_addr, rd_req, mem_rvalid;
  logic [31:0] mem_rdata, rd_addr, data_out;
  logic        read_enable, data_valid, record_done, empty, overflow;
  int total = 0, bad = 0;

  result_readback_fsm dut (
    .clk(clk), .n_rst(n_rst), .inc_addr(inc_addr), .rd_req(rd_req),
    .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid), .rd_addr(rd_addr),
    .read_enable(read_enable), .data_out(data_out), .data_valid(data_valid),
    .record_done(record_done), .empty(empty), .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // in = {n_rst, inc_addr, rd_req, mem_rvalid}; fl = {read_enable, data_valid, record_done, empty}
  typedef struct {
    logic [3:0]  in;
    logic [31:0] d;
    logic [31:0] addr;
    logic [3:0]  fl;
    logic [31:0] dout;
    logic        ov;
  } vec_t;
  vec_t tbl[25];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step(input logic nr, input logic inc, input logic req, input logic vld, input logic [31:0] d);
    n_rst = nr; inc_addr = inc; rd_req = req; mem_rvalid = vld; mem_rdata = d;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] flags();
    return 32'({read_enable, data_valid, record_done, empty});
  endfunction

  task automatic chk_reset_state(input string nm);
    chk({nm, "_addr"}, rd_addr, 32'h0000060E);
    chk({nm, "_flags"}, flags(), 32'h1);
    chk({nm, "_dout"}, data_out, 32'h0);
    chk({nm, "_ovf"}, 32'(overflow), 32'h0);
  endtask

  // reads one record starting from IDLE; lat >= 1 is the number of cycles after ISSUE without rvalid
  task automatic read_record(input logic [31:0] base, input int lat);
    step(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
    chk("rr_issue_re", 32'(read_enable), 32'h1);
    chk("rr_issue_addr", rd_addr, base);
    for (int w = 0; w < 4; w++) begin
      for (int l = 0; l < lat; l++) begin
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        chk("rr_wait_re", 32'(read_enable), 32'h0);
        chk("rr_wait_addr", rd_addr, base + 32'(4 * w));
      end
      step(1'b1, 1'b0, 1'b0, 1'b1, 32'hD000_0000 + base + 32'(w));
      chk("rr_dv", 32'(data_valid), 32'h1);
      chk("rr_dout", data_out, 32'hD000_0000 + base + 32'(w));
      chk("rr_done", 32'(record_done), 32'(w == 3));
      if (w < 3) begin
        chk("rr_next_re", 32'(read_enable), 32'h1);
        chk("rr_next_addr", rd_addr, base + 32'(4 * (w + 1)));
      end
    end
  endtask

  initial begin
    tbl[0]  = '{4'b0000, 32'h0,    32'h060E, 4'b0001, 32'h0,   1'b0};
    tbl[1]  = '{4'b0000, 32'h0,    32'h060E, 4'b0001, 32'h0,   1'b0};
    tbl[2]  = '{4'b1010, 32'h0,    32'h060E, 4'b0001, 32'h0,   1'b0};
    tbl[3]  = '{4'b1010, 32'h0,    32'h060E, 4'b0001, 32'h0,   1'b0};
    tbl[4]  = '{4'b1100, 32'h0,    32'h060E, 4'b0000, 32'h0,   1'b0};
    tbl[5]  = '{4'b1010, 32'h0,    32'h060E, 4'b1000, 32'h0,   1'b0};
    tbl[6]  = '{4'b1001, 32'hDEAD, 32'h060E, 4'b0000, 32'h0,   1'b0};
    tbl[7]  = '{4'b1001, 32'hAA0,  32'h0612, 4'b1100, 32'hAA0, 1'b0};
    tbl[8]  = '{4'b1000, 32'h0,    32'h0612, 4'b0000, 32'hAA0, 1'b0};
    tbl[9]  = '{4'b1001, 32'hAA1,  32'h0616, 4'b1100, 32'hAA1, 1'b0};
    tbl[10] = '{4'b1000, 32'h0,    32'h0616, 4'b0000, 32'hAA1, 1'b0};
    tbl[11] = '{4'b1001, 32'hAA2,  32'h061A, 4'b1100, 32'hAA2, 1'b0};
    tbl[12] = '{4'b1000, 32'h0,    32'h061A, 4'b0000, 32'hAA2, 1'b0};
    tbl[13] = '{4'b1001, 32'hAA3,  32'h0C1C, 4'b0111, 32'hAA3, 1'b0};
    tbl[14] = '{4'b1010, 32'h0,    32'h0C1C, 4'b0001, 32'hAA3, 1'b0};
    tbl[15] = '{4'b1100, 32'h0,    32'h0C1C, 4'b0000, 32'hAA3, 1'b0};
    tbl[16] = '{4'b1010, 32'h0,    32'h0C1C, 4'b1000, 32'hAA3, 1'b0};
    tbl[17] = '{4'b1000, 32'h0,    32'h0C1C, 4'b0000, 32'hAA3, 1'b0};
    tbl[18] = '{4'b1001, 32'hB0,   32'h0C20, 4'b1100, 32'hB0,  1'b0};
    tbl[19] = '{4'b1000, 32'h0,    32'h0C20, 4'b0000, 32'hB0,  1'b0};
    tbl[20] = '{4'b1001, 32'hB1,   32'h0C24, 4'b1100, 32'hB1,  1'b0};
    tbl[21] = '{4'b1000, 32'h0,    32'h0C24, 4'b0000, 32'hB1,  1'b0};
    tbl[22] = '{4'b1001, 32'hB2,   32'h0C28, 4'b1100, 32'hB2,  1'b0};
    tbl[23] = '{4'b1000, 32'h0,    32'h0C28, 4'b0000, 32'hB2,  1'b0};
    tbl[24] = '{4'b1101, 32'hB3,   32'h122A, 4'b0110, 32'hB3,  1'b0};
    n_rst = 1'b0; inc_addr = 1'b0; rd_req = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    for (int i = 0; i < 25; i++) begin
      step(tbl[i].in[3], tbl[i].in[2], tbl[i].in[1], tbl[i].in[0], tbl[i].d);
      chk($sformatf("vec%0d_addr", i), rd_addr, tbl[i].addr);
      chk($sformatf("vec%0d_flags", i), flags(), 32'(tbl[i].fl));
      chk($sformatf("vec%0d_dout", i), data_out, tbl[i].dout);
      chk($sformatf("vec%0d_ovf", i), 32'(overflow), 32'(tbl[i].ov));
    end
    // pending is still 1 after the simultaneous case; read it with a 6-cycle memory latency
    read_record(32'h122A, 6);
    chk("lat_empty", 32'(empty), 32'h1);
    chk("lat_next_addr", rd_addr, 32'h1838);
    // reset during the WAIT of word 2, with a same-cycle rvalid that must be dropped
    step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
    chk("mid_issue_addr", rd_addr, 32'h1838);
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 32'hC0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 32'hC1);
    chk("mid_w2_addr", rd_addr, 32'h1840);
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF);
    chk_reset_state("mid_rst");
    step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
    chk("restart_re", 32'(read_enable), 32'h1);
    chk("restart_addr", rd_addr, 32'h060E);
    // overflow and slot wrap
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    chk_reset_state("ovf_rst");
    for (int i = 0; i < 9; i++) begin
      step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
      chk($sformatf("ovf_inc%0d_ovf", i), 32'(overflow), 32'(i == 8));
      chk($sformatf("ovf_inc%0d_empty", i), 32'(empty), 32'h0);
    end
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    for (int k = 1; k <= 8; k++) begin
      read_record(32'h060E * 32'(k), 1);
      chk($sformatf("wrap%0d_empty", k), 32'(empty), 32'(k == 8));
      chk($sformatf("wrap%0d_ovf", k), 32'(overflow), 32'h1);
    end
    chk("wrap_addr", rd_addr, 32'h060E);
    step(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
    chk("wrap_empty_req_re", 32'(read_enable), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
